network_interface_controller: RTL and testbench

Single-flit network interface controller sitting between the four-stage processor's NIC port and one mesh router port. Exposes four 64-bit memory-mapped registers (input channel buffer, input status, output channel buffer, output status) to the processor. Moves one packet at a time in each direction over a ready/send handshake with the router. Uses router polarity to schedule outbound virtual channels.

---
 rtl/network_interface_controller.sv | 111 +++++++++++
 tb/tb_network_interface_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/network_interface_controller.sv
// Single-flit network interface controller between the processor NIC port and one
// mesh router port. The processor sees four 64-bit registers selected by addr:
//   00 input buffer (reading it while full frees the buffer)
//   01 input status  {63'b0, in_full}
//   10 output buffer (writes accepted only while empty)
//   11 output status {63'b0, out_full}
// One packet is held per direction. The outbound virtual channel is out_buf[0] (the MSB
// in [0:63] order), and a packet leaves only in a cycle whose router polarity matches it.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   nicEn, nicWrEn    processor access enable / write enable
//   addr, d_in        register select, processor write data
//   d_out             registered processor read data
//   net_si/net_ri/net_di   inbound send, ready and packet
//   net_so/net_ro/net_do   outbound send, ready and packet
//   net_polarity      router polarity for the current cycle
module network_interface_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic [0:1]  addr,
  input  logic [0:63] d_in,
  output logic [0:63] d_out,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_polarity
);

  localparam logic [0:1] AddrInBuf     = 2'b00;
  localparam logic [0:1] AddrInStatus  = 2'b01;
  localparam logic [0:1] AddrOutBuf    = 2'b10;
  localparam logic [0:1] AddrOutStatus = 2'b11;

  logic [0:63] in_buf_q, in_buf_d;
  logic        in_full_q, in_full_d;
  logic [0:63] out_buf_q, out_buf_d;
  logic        out_full_q, out_full_d;
  logic [0:63] d_out_q, d_out_d;

  logic rd_en, wr_en;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  // Router-facing outputs depend only on registered state plus the router's own inputs.
  assign net_ri = ~in_full_q;
  assign net_so = out_full_q & net_ro & (out_buf_q[0] == net_polarity);
  assign net_do = out_full_q ? out_buf_q : 64'd0;
  assign d_out  = d_out_q;

  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    d_out_d    = d_out_q;

    if (rd_en) begin
      unique case (addr)
        AddrInBuf:     d_out_d = in_buf_q;
        AddrInStatus:  d_out_d = {63'd0, in_full_q};
        AddrOutBuf:    d_out_d = out_buf_q;
        AddrOutStatus: d_out_d = {63'd0, out_full_q};
        default:       d_out_d = d_out_q;
      endcase
    end

    // Freeing and filling the input buffer are exclusive: a free needs in_full=1, an
    // arrival needs in_full=0.
    if (rd_en && (addr == AddrInBuf) && in_full_q) begin
      in_full_d = 1'b0;
    end
    if (net_si && net_ri) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    // A send needs out_full=1 and a write needs out_full=0, so a write in the cycle a
    // send completes is dropped.
    if (net_so) begin
      out_full_d = 1'b0;
    end
    if (wr_en && (addr == AddrOutBuf) && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_buf_q   <= 64'd0;
      in_full_q  <= 1'b0;
      out_buf_q  <= 64'd0;
      out_full_q <= 1'b0;
      d_out_q    <= 64'd0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      d_out_q    <= d_out_d;
    end
  end

endmodule

// File: tb/tb_network_interface_controller.sv
module tb_network_interface_controller;

  logic        clk;
  logic        reset;
  logic        nicEn;
  logic        nicWrEn;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int n_checks = 0;
  int n_errors = 0;

  network_interface_controller dut (
    .clk          (clk),
    .reset        (reset),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nicEn        = 1'b0;
    nicWrEn      = 1'b0;
    addr         = 2'b00;
    d_in         = 64'd0;
    net_si       = 1'b0;
    net_di       = 64'd0;
    net_ro       = 1'b0;
    net_polarity = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [63:0] val);
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    addr    = a;
    step();
    nicEn   = 1'b0;
    #1;
    val = d_out;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] val);
    nicEn   = 1'b1;
    nicWrEn = 1'b1;
    addr    = a;
    d_in    = val;
    step();
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
    #1;
  endtask

  logic [63:0] v;

  initial begin
    // Reset with random activity on every input.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nicEn        = 1'($urandom);
      nicWrEn      = 1'($urandom);
      addr         = 2'($urandom);
      d_in         = {$urandom, $urandom};
      net_si       = 1'($urandom);
      net_di       = {$urandom, $urandom};
      net_ro       = 1'($urandom);
      net_polarity = 1'($urandom);
      step();
    end
    reset = 1'b1;
    idle();
    #1;
    check("rst_d_out", d_out, 64'd0);
    check("rst_net_ri", 64'(net_ri), 64'd1);
    net_ro = 1'b1;
    #1;
    check("rst_net_so", 64'(net_so), 64'd0);
    check("rst_net_do", net_do, 64'd0);
    net_ro = 1'b0;
    rd(2'b01, v);
    check("rst_in_status", v, 64'd0);
    rd(2'b11, v);
    check("rst_out_status", v, 64'd0);

    // Send path: VC bit (MSB) is 1, so only a polarity=1 cycle sends.
    wr(2'b10, 64'h8000_0000_0000_00AA);
    rd(2'b11, v);
    check("send_status_full", v, 64'd1);
    net_ro       = 1'b1;
    net_polarity = 1'b0;
    #1;
    check("send_pol0_so", 64'(net_so), 64'd0);
    check("send_pol0_do", net_do, 64'h8000_0000_0000_00AA);
    step();
    net_polarity = 1'b1;
    #1;
    check("send_pol1_so", 64'(net_so), 64'd1);
    check("send_pol1_do", net_do, 64'h8000_0000_0000_00AA);
    step();
    net_polarity = 1'b0;
    #1;
    check("send_after_so", 64'(net_so), 64'd0);
    check("send_after_do", net_do, 64'd0);
    net_ro = 1'b0;
    rd(2'b11, v);
    check("send_status_empty", v, 64'd0);

    // Output full: second write is dropped.
    wr(2'b10, 64'h1);
    wr(2'b10, 64'h2);
    rd(2'b10, v);
    check("outfull_buf", v, 64'h1);
    // Write in the cycle a send completes is dropped (VC 0, polarity 0).
    net_ro       = 1'b1;
    net_polarity = 1'b0;
    nicEn        = 1'b1;
    nicWrEn      = 1'b1;
    addr         = 2'b10;
    d_in         = 64'h4;
    #1;
    check("drain_so", 64'(net_so), 64'd1);
    step();
    idle();
    #1;
    rd(2'b11, v);
    check("sendwr_status", v, 64'd0);
    rd(2'b10, v);
    check("sendwr_buf", v, 64'h1);

    // Receive path.
    net_si = 1'b1;
    net_di = 64'hDEAD_BEEF_0000_0001;
    #1;
    check("rx_ri_before", 64'(net_ri), 64'd1);
    step();
    net_si = 1'b0;
    net_di = 64'd0;
    #1;
    check("rx_ri_full", 64'(net_ri), 64'd0);
    rd(2'b01, v);
    check("rx_status_full", v, 64'd1);
    rd(2'b00, v);
    check("rx_data", v, 64'hDEAD_BEEF_0000_0001);
    check("rx_ri_freed", 64'(net_ri), 64'd1);
    rd(2'b01, v);
    check("rx_status_empty", v, 64'd0);

    // Empty read returns stale data and changes nothing.
    rd(2'b00, v);
    check("empty_stale", v, 64'hDEAD_BEEF_0000_0001);
    check("empty_ri", 64'(net_ri), 64'd1);
    rd(2'b01, v);
    check("empty_status", v, 64'd0);

    // Read of 00 alongside an arrival returns the old buffer and sets in_full.
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    addr    = 2'b00;
    net_si  = 1'b1;
    net_di  = 64'h1234;
    step();
    idle();
    #1;
    check("simul_old_data", d_out, 64'hDEAD_BEEF_0000_0001);
    check("simul_ri", 64'(net_ri), 64'd0);
    rd(2'b00, v);
    check("simul_new_data", v, 64'h1234);

    // Reset mid-operation with both buffers full.
    net_si = 1'b1;
    net_di = 64'h55;
    step();
    net_si = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_0001);
    check("mid_ri_full", 64'(net_ri), 64'd0);
    reset = 1'b0;
    step();
    reset        = 1'b1;
    net_ro       = 1'b1;
    net_polarity = 1'b1;
    #1;
    check("mid_ri", 64'(net_ri), 64'd1);
    check("mid_so", 64'(net_so), 64'd0);
    check("mid_do", net_do, 64'd0);
    check("mid_d_out", d_out, 64'd0);
    net_ro = 1'b0;
    rd(2'b01, v);
    check("mid_in_status", v, 64'd0);
    rd(2'b11, v);
    check("mid_out_status", v, 64'd0);
    rd(2'b00, v);
    check("mid_in_buf", v, 64'd0);
    rd(2'b10, v);
    check("mid_out_buf", v, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
